// File: rtl/multi_channel_sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_channel_sync_filter: N-channel synchronizer + debounce, edge pulses  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module multi_channel_sync_filter #(
  parameter int                      NUM_CHANNELS  = 4,
  parameter int                      STAGES        = 2,
  parameter int                      FILTER_CYCLES = 4,
  parameter logic [NUM_CHANNELS-1:0] RESET_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] in,
  output logic [NUM_CHANNELS-1:0] out,
  output logic [NUM_CHANNELS-1:0] rise,
  output logic [NUM_CHANNELS-1:0] fall,
  output logic                    any_edge
);

  localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("multi_channel_sync_filter: STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("multi_channel_sync_filter: FILTER_CYCLES must be >= 1");
    end
    if (NUM_CHANNELS < 1) begin : g_bad_channels
      $error("multi_channel_sync_filter: NUM_CHANNELS must be >= 1");
    end
  endgenerate

  logic [NUM_CHANNELS-1:0] sync;
  logic [NUM_CHANNELS-1:0] fire;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    // Double-underscore name lets CDC-aware simulation locate the chain flops.
    logic [STAGES-1:0] __sync_chain__;
    logic [CNT_W-1:0]  cnt;
    logic              out_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        __sync_chain__ <= {STAGES{RESET_VALUE[i]}};
      end else if (enable) begin
        __sync_chain__ <= {__sync_chain__[STAGES-2:0], in[i]};
      end
    end

    assign sync[i] = __sync_chain__[STAGES-1];
    assign fire[i] = enable && (sync[i] != out_q) && (cnt == CNT_LAST);

    // Pulses are rewritten every edge, so they self-clear and drop while disabled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q  <= RESET_VALUE[i];
        cnt    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= fire[i] & sync[i];
        fall_q <= fire[i] & ~sync[i];
        if (enable) begin
          if (sync[i] == out_q) begin
            cnt <= '0;
          end else if (fire[i]) begin
            out_q <= sync[i];
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      end
    end

    assign out[i]  = out_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_edge <= 1'b0;
    end else begin
      any_edge <= |fire;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_sync_filter.sv
`default_nettype none
// Scoreboard bench: two parameterisations driven in lockstep, compared against a
// delay-line + run-length reference model.
module tb_multi_channel_sync_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] in_v = 4'b0000;

  logic [3:0] out0, rise0, fall0, out1, rise1, fall1;
  logic       any0, any1;

  always #5 clk = ~clk;

  multi_channel_sync_filter dut0 (
    .clk(clk), .rst(rst), .enable(enable), .in(in_v),
    .out(out0), .rise(rise0), .fall(fall0), .any_edge(any0)
  );

  multi_channel_sync_filter #(
    .NUM_CHANNELS(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VALUE(4'b0101)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .in(in_v),
    .out(out1), .rise(rise1), .fall(fall1), .any_edge(any1)
  );

  int errors = 0;
  int checks = 0;
  logic [25:0] exp_q[$];

  // Reference model: per instance, a delay line of captured inputs and a count of
  // consecutive enabled cycles the delayed value disagrees with the output.
  int         stg[2] = '{2, 3};
  int         fcy[2] = '{4, 1};
  logic [3:0] rv[2]  = '{4'b0000, 4'b0101};
  logic [3:0] pipe[2][8];
  logic [3:0] m_out[2], m_rise[2], m_fall[2];
  logic       m_any[2];
  int         run[2][4];

  task automatic model_reset(input int m);
    for (int k = 0; k < 8; k++) pipe[m][k] = rv[m];
    m_out[m] = rv[m]; m_rise[m] = 4'b0; m_fall[m] = 4'b0; m_any[m] = 1'b0;
    for (int c = 0; c < 4; c++) run[m][c] = 0;
  endtask

  task automatic model_edge(input int m);
    logic [3:0] s;
    if (rst) begin
      model_reset(m);
    end else if (!enable) begin
      m_rise[m] = 4'b0; m_fall[m] = 4'b0; m_any[m] = 1'b0;
    end else begin
      s = pipe[m][stg[m]-1];
      m_rise[m] = 4'b0; m_fall[m] = 4'b0;
      for (int c = 0; c < 4; c++) begin
        if (s[c] == m_out[m][c]) begin
          run[m][c] = 0;
        end else begin
          run[m][c] = run[m][c] + 1;
          if (run[m][c] >= fcy[m]) begin
            m_out[m][c]  = s[c];
            m_rise[m][c] = s[c];
            m_fall[m][c] = ~s[c];
            run[m][c]    = 0;
          end
        end
      end
      for (int k = 7; k > 0; k--) pipe[m][k] = pipe[m][k-1];
      pipe[m][0] = in_v;
      m_any[m] = |(m_rise[m] | m_fall[m]);
    end
  endtask

  function automatic logic [12:0] pack(input int m);
    return {m_out[m], m_rise[m], m_fall[m], m_any[m]};
  endfunction

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got out/rise/fall/any=%b required %b", name, $time, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] i, input logic e, input logic r);
    @(negedge clk);
    in_v = i; enable = e; rst = r;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    exp_q.push_back({pack(0), pack(1)});
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    chk("async_rst_dut0", {out0, rise0, fall0, any0}, pack(0));
    chk("async_rst_dut1", {out1, rise1, fall1, any1}, pack(1));
  endtask

  // Monitor: pops the expectation for each completed edge, away from the edge.
  always @(negedge clk) begin
    logic [25:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dut0", {out0, rise0, fall0, any0}, e[25:13]);
      chk("dut1", {out1, rise1, fall1, any1}, e[12:0]);
      chk("dut0_rise_and_fall", {9'b0, rise0 & fall0}, 13'b0);
      chk("dut1_rise_and_fall", {9'b0, rise1 & fall1}, 13'b0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic       e;
    #1 in_v = 4'b1010; rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    chk("reset_dut0", {out0, rise0, fall0, any0}, pack(0));
    chk("reset_dut1", {out1, rise1, fall1, any1}, pack(1));
    repeat (3) step(4'b1010, 1'b1, 1'b1);
    repeat (12) step(4'b1010, 1'b1, 1'b0);

    // Glitches on channel 0: too short, then exactly long enough.
    repeat (3) step(4'b1011, 1'b1, 1'b0);
    repeat (12) step(4'b1010, 1'b1, 1'b0);
    repeat (4) step(4'b1011, 1'b1, 1'b0);
    repeat (12) step(4'b1010, 1'b1, 1'b0);

    // Enable gating in the middle of a channel-2 count.
    repeat (4) step(4'b1110, 1'b1, 1'b0);
    repeat (10) step(4'b1110, 1'b0, 1'b0);
    repeat (10) step(4'b1110, 1'b1, 1'b0);

    // Async reset while counting down from all-ones.
    repeat (12) step(4'b1111, 1'b1, 1'b0);
    repeat (4) step(4'b0000, 1'b1, 1'b0);
    async_reset_check();
    repeat (2) step(4'b0000, 1'b1, 1'b1);
    repeat (12) step(4'b0000, 1'b1, 1'b0);

    // Random traffic: sparse per-channel toggles so some changes survive the filter.
    r = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
      e = ($urandom_range(0, 9) != 0);
      step(r, e, 1'b0);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", {9'b0, 4'(exp_q.size())}, 13'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
